// File: rtl/game_sequencer.sv
// game_sequencer: level/phase timer for a multi-player counting game.
// In: Clk100M, reset (sync, active-low), tick1Hz, start, userUp/userDown
// per player, magicCount. Out: phase, curLevel, secsLeft, genStart/genStop,
// userCount (packed per player), alive, levelDone, win, lose (all registered).
module game_sequencer #(
  parameter int NUM_PLAYERS = 2,
  parameter int COUNT_W     = 8,
  parameter int LEVEL_W     = 4,
  parameter int MAX_LEVEL   = 9,
  parameter int PRELIM_SECS = 3,
  parameter int GAME_SECS   = 10,
  parameter int ANSWER_SECS = 5,
  parameter int POST_SECS   = 3,
  parameter int TOLERANCE   = 0
) (
  input  logic                           Clk100M,
  input  logic                           reset,
  input  logic                           tick1Hz,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         userUp,
  input  logic [NUM_PLAYERS-1:0]         userDown,
  input  logic [COUNT_W-1:0]             magicCount,
  output logic [2:0]                     phase,
  output logic [LEVEL_W-1:0]             curLevel,
  output logic [7:0]                     secsLeft,
  output logic                           genStart,
  output logic                           genStop,
  output logic [NUM_PLAYERS*COUNT_W-1:0] userCount,
  output logic [NUM_PLAYERS-1:0]         alive,
  output logic                           levelDone,
  output logic                           win,
  output logic                           lose
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRELIM = 3'd1,
    GAME   = 3'd2,
    ANSWER = 3'd3,
    POST   = 3'd4,
    OVER   = 3'd5
  } stateT;

  localparam logic [7:0] prelimS = 8'(PRELIM_SECS);
  localparam logic [7:0] gameS   = 8'(GAME_SECS);
  localparam logic [7:0] answerS = 8'(ANSWER_SECS);
  localparam logic [7:0] postS   = 8'(POST_SECS);
  localparam logic [COUNT_W:0] tol = (COUNT_W+1)'(TOLERANCE);
  localparam logic [LEVEL_W-1:0] lastLvl = LEVEL_W'(MAX_LEVEL);
  localparam logic [COUNT_W-1:0] cntMax = '1;

  stateT state;
  logic [COUNT_W-1:0] magicLatch;
  logic timed;
  logic expire;

  assign phase  = state;
  assign timed  = (state == PRELIM) || (state == GAME) ||
                  (state == ANSWER) || (state == POST);
  assign expire = timed && tick1Hz && (secsLeft == 8'd1);

  function automatic logic [COUNT_W-1:0] stepCount(
    input logic [COUNT_W-1:0] c,
    input logic               u,
    input logic               d
  );
    logic [COUNT_W-1:0] r;
    r = c;
    if (u && !d && c != cntMax)
      r = c + COUNT_W'(1);
    else if (d && !u && c != '0)
      r = c - COUNT_W'(1);
    return r;
  endfunction

  // Distance taken one bit wider so the unsigned subtract cannot wrap.
  function automatic logic missed(
    input logic [COUNT_W-1:0] c,
    input logic [COUNT_W-1:0] m
  );
    logic [COUNT_W:0] a;
    logic [COUNT_W:0] b;
    logic [COUNT_W:0] diff;
    a    = {1'b0, c};
    b    = {1'b0, m};
    diff = (a >= b) ? a - b : b - a;
    return diff > tol;
  endfunction

  always_ff @(posedge Clk100M) begin
    if (!reset) begin
      state      <= IDLE;
      curLevel   <= LEVEL_W'(1);
      secsLeft   <= '0;
      userCount  <= '0;
      alive      <= '1;
      genStart   <= 1'b0;
      genStop    <= 1'b0;
      levelDone  <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
      magicLatch <= '0;
    end else begin
      genStart  <= 1'b0;
      genStop   <= 1'b0;
      levelDone <= 1'b0;
      if (genStop)
        magicLatch <= magicCount;
      if (state == GAME || state == ANSWER)
        for (int i = 0; i < NUM_PLAYERS; i++)
          if (alive[i])
            userCount[i*COUNT_W +: COUNT_W] <= stepCount(
              userCount[i*COUNT_W +: COUNT_W], userUp[i], userDown[i]);
      if (timed && tick1Hz && !expire)
        secsLeft <= secsLeft - 8'd1;
      unique case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= PRELIM;
            secsLeft  <= prelimS;
            curLevel  <= LEVEL_W'(1);
            alive     <= '1;
            win       <= 1'b0;
            lose      <= 1'b0;
            userCount <= '0;
          end
        end
        PRELIM: begin
          if (expire) begin
            state     <= GAME;
            secsLeft  <= gameS;
            genStart  <= 1'b1;
            userCount <= '0;
          end
        end
        GAME: begin
          if (expire) begin
            state    <= ANSWER;
            secsLeft <= answerS;
            genStop  <= 1'b1;
          end
        end
        ANSWER: begin
          if (expire) begin
            state    <= POST;
            secsLeft <= postS;
            for (int i = 0; i < NUM_PLAYERS; i++)
              if (missed(userCount[i*COUNT_W +: COUNT_W], magicLatch))
                alive[i] <= 1'b0;
          end
        end
        POST: begin
          if (expire) begin
            if (alive == '0) begin
              state    <= OVER;
              secsLeft <= '0;
              lose     <= 1'b1;
            end else if (curLevel == lastLvl) begin
              state    <= OVER;
              secsLeft <= '0;
              win      <= 1'b1;
            end else begin
              state     <= PRELIM;
              secsLeft  <= prelimS;
              curLevel  <= curLevel + LEVEL_W'(1);
              levelDone <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scoreboard bench for game_sequencer.
// Expected snapshots are queued by stimulus and popped by a monitor.
module tb_game_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN, tick, start, startW;
  logic [1:0] up, down;
  logic [7:0] magic;

  logic [2:0]  phA, phB;
  logic [3:0]  lvlA, lvlB;
  logic [7:0]  secsA, secsB;
  logic        gsA, gpA, ldA, wA, lA;
  logic        gsB, gpB, ldB, wB, lB;
  logic [15:0] cntA, cntB;
  logic [1:0]  alvA, alvB;

  game_sequencer dutA (
    .Clk100M(clk), .reset(rstN), .tick1Hz(tick), .start(start),
    .userUp(up), .userDown(down), .magicCount(magic),
    .phase(phA), .curLevel(lvlA), .secsLeft(secsA),
    .genStart(gsA), .genStop(gpA), .userCount(cntA), .alive(alvA),
    .levelDone(ldA), .win(wA), .lose(lA)
  );

  game_sequencer #(.MAX_LEVEL(1)) dutB (
    .Clk100M(clk), .reset(rstN), .tick1Hz(tick), .start(startW),
    .userUp(up), .userDown(down), .magicCount(magic),
    .phase(phB), .curLevel(lvlB), .secsLeft(secsB),
    .genStart(gsB), .genStop(gpB), .userCount(cntB), .alive(alvB),
    .levelDone(ldB), .win(wB), .lose(lB)
  );

  typedef struct packed {
    logic [2:0] ph;
    logic [3:0] lvl;
    logic [7:0] secs;
    logic [7:0] c1;
    logic [7:0] c0;
    logic [1:0] alv;
    logic gs, gp, ld, w, l;
  } snapT;

  snapT qA[$];
  snapT qB[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   evA = 0;
  int   evB = 0;
  bit   monOn = 1'b0;
  bit   probeA = 1'b0;
  bit   probeB = 1'b0;
  logic [2:0] prevA, prevB;

  function automatic snapT mk(
    input logic [2:0] ph, input logic [3:0] lvl, input logic [7:0] secs,
    input logic [7:0] c0, input logic [7:0] c1, input logic [1:0] alv,
    input logic gs, input logic gp, input logic ld,
    input logic w, input logic l);
    snapT s;
    s.ph = ph; s.lvl = lvl; s.secs = secs; s.c0 = c0; s.c1 = c1;
    s.alv = alv; s.gs = gs; s.gp = gp; s.ld = ld; s.w = w; s.l = l;
    return s;
  endfunction

  task automatic chk(input string nm, input int idx, input bit has,
                     input snapT act, input snapT exp);
    nChecks++;
    if (!has) begin
      nFails++;
      $display("FAIL %s ev%0d unexpected: actual ph=%0d lvl=%0d secs=%0d cnt=%0d/%0d alive=%b gs=%b gp=%b ld=%b w=%b l=%b, required none",
               nm, idx, act.ph, act.lvl, act.secs, act.c0, act.c1,
               act.alv, act.gs, act.gp, act.ld, act.w, act.l);
    end else if (act !== exp) begin
      nFails++;
      $display("FAIL %s ev%0d: actual ph=%0d lvl=%0d secs=%0d cnt=%0d/%0d alive=%b gs=%b gp=%b ld=%b w=%b l=%b, required ph=%0d lvl=%0d secs=%0d cnt=%0d/%0d alive=%b gs=%b gp=%b ld=%b w=%b l=%b",
               nm, idx, act.ph, act.lvl, act.secs, act.c0, act.c1,
               act.alv, act.gs, act.gp, act.ld, act.w, act.l,
               exp.ph, exp.lvl, exp.secs, exp.c0, exp.c1,
               exp.alv, exp.gs, exp.gp, exp.ld, exp.w, exp.l);
    end
  endtask

  // Monitor: any phase change, pulse, or probe request is an output event.
  always @(negedge clk) begin
    snapT a, b, e;
    bit   has;
    a = mk(phA, lvlA, secsA, cntA[7:0], cntA[15:8], alvA,
           gsA, gpA, ldA, wA, lA);
    b = mk(phB, lvlB, secsB, cntB[7:0], cntB[15:8], alvB,
           gsB, gpB, ldB, wB, lB);
    if (monOn && (phA != prevA || gsA || gpA || ldA || probeA)) begin
      has = qA.size() > 0;
      e = '0;
      if (has) e = qA.pop_front();
      chk("dutA", evA, has, a, e);
      evA++;
    end
    if (monOn && (phB != prevB || gsB || gpB || ldB || probeB)) begin
      has = qB.size() > 0;
      e = '0;
      if (has) e = qB.pop_front();
      chk("dutB", evB, has, b, e);
      evB++;
    end
    prevA = phA;
    prevB = phB;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask

  task automatic blip(input logic [1:0] u, input logic [1:0] d,
                      input int n);
    repeat (n) begin
      up = u; down = d; cyc();
      up = '0; down = '0; cyc();
    end
  endtask

  task automatic probe(input bit selB, input snapT e);
    if (selB) begin
      qB.push_back(e); probeB = 1'b1; cyc(); probeB = 1'b0;
    end else begin
      qA.push_back(e); probeA = 1'b1; cyc(); probeA = 1'b0;
    end
  endtask

  initial begin
    rstN = 1'b0; tick = 1'b0; start = 1'b0; startW = 1'b0;
    up = '0; down = '0; magic = '0;
    repeat (3) cyc();
    monOn = 1'b1;
    probe(0, mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0));
    probe(1, mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0));
    rstN = 1'b1; cyc();

    // Start with a coincident tick: secsLeft must load 3, not 2.
    qA.push_back(mk(1, 1, 3, 0, 0, 2'b11, 0, 0, 0, 0, 0));
    start = 1'b1; tick = 1'b1; cyc();
    start = 1'b0; tick = 1'b0; cyc();
    ticks(1);
    probe(0, mk(1, 1, 2, 0, 0, 2'b11, 0, 0, 0, 0, 0));
    start = 1'b1; cyc(); start = 1'b0;
    probe(0, mk(1, 1, 2, 0, 0, 2'b11, 0, 0, 0, 0, 0));
    qA.push_back(mk(2, 1, 10, 0, 0, 2'b11, 1, 0, 0, 0, 0));
    ticks(2);

    // Level 1: magic 5, player0 5 ups, player1 4 ups.
    magic = 8'd5;
    blip(2'b11, 2'b00, 4);
    blip(2'b01, 2'b00, 1);
    probe(0, mk(2, 1, 10, 5, 4, 2'b11, 0, 0, 0, 0, 0));
    qA.push_back(mk(3, 1, 5, 5, 4, 2'b11, 0, 1, 0, 0, 0));
    ticks(10);
    magic = 8'd9;
    qA.push_back(mk(4, 1, 3, 5, 4, 2'b01, 0, 0, 0, 0, 0));
    ticks(5);
    qA.push_back(mk(1, 2, 3, 5, 4, 2'b01, 0, 0, 1, 0, 0));
    ticks(3);

    // Level 2: saturation, dead-player blips, then both miss.
    qA.push_back(mk(2, 2, 10, 0, 0, 2'b01, 1, 0, 0, 0, 0));
    ticks(3);
    magic = 8'd100;
    blip(2'b00, 2'b01, 3);
    probe(0, mk(2, 2, 10, 0, 0, 2'b01, 0, 0, 0, 0, 0));
    blip(2'b10, 2'b00, 2);
    probe(0, mk(2, 2, 10, 0, 0, 2'b01, 0, 0, 0, 0, 0));
    blip(2'b01, 2'b00, 260);
    probe(0, mk(2, 2, 10, 255, 0, 2'b01, 0, 0, 0, 0, 0));
    blip(2'b00, 2'b01, 1);
    blip(2'b01, 2'b01, 1);
    probe(0, mk(2, 2, 10, 254, 0, 2'b01, 0, 0, 0, 0, 0));
    qA.push_back(mk(3, 2, 5, 254, 0, 2'b01, 0, 1, 0, 0, 0));
    ticks(10);
    qA.push_back(mk(4, 2, 3, 254, 0, 2'b00, 0, 0, 0, 0, 0));
    ticks(5);
    qA.push_back(mk(5, 2, 0, 254, 0, 2'b00, 0, 0, 0, 0, 1));
    ticks(3);
    ticks(2);
    probe(0, mk(5, 2, 0, 254, 0, 2'b00, 0, 0, 0, 0, 1));

    // Restart from OVER.
    qA.push_back(mk(1, 1, 3, 0, 0, 2'b11, 0, 0, 0, 0, 0));
    start = 1'b1; cyc(); start = 1'b0; cyc();
    qA.push_back(mk(2, 1, 10, 0, 0, 2'b11, 1, 0, 0, 0, 0));
    ticks(3);
    ticks(1);
    blip(2'b11, 2'b00, 2);
    blip(2'b01, 2'b00, 1);
    probe(0, mk(2, 1, 9, 3, 2, 2'b11, 0, 0, 0, 0, 0));

    // Reset mid-GAME beats start, tick and blips in the same cycle.
    qA.push_back(mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0));
    rstN = 1'b0; tick = 1'b1; start = 1'b1; up = 2'b11; cyc();
    rstN = 1'b1; tick = 1'b0; start = 1'b0; up = 2'b00;
    repeat (4) cyc();
    probe(0, mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0));

    // MAX_LEVEL=1 instance: player0 correct wins without levelDone.
    qB.push_back(mk(1, 1, 3, 0, 0, 2'b11, 0, 0, 0, 0, 0));
    startW = 1'b1; cyc(); startW = 1'b0; cyc();
    qB.push_back(mk(2, 1, 10, 0, 0, 2'b11, 1, 0, 0, 0, 0));
    ticks(3);
    magic = 8'd7;
    blip(2'b01, 2'b00, 7);
    qB.push_back(mk(3, 1, 5, 7, 0, 2'b11, 0, 1, 0, 0, 0));
    ticks(10);
    qB.push_back(mk(4, 1, 3, 7, 0, 2'b01, 0, 0, 0, 0, 0));
    ticks(5);
    qB.push_back(mk(5, 1, 0, 7, 0, 2'b01, 0, 0, 0, 1, 0));
    ticks(3);
    ticks(2);
    probe(1, mk(5, 1, 0, 7, 0, 2'b01, 0, 0, 0, 1, 0));
    repeat (4) cyc();

    nChecks++;
    if (qA.size() != 0) begin
      nFails++;
      $display("FAIL dutA_drain: actual %0d pending events, required 0",
               qA.size());
    end
    nChecks++;
    if (qB.size() != 0) begin
      nFails++;
      $display("FAIL dutB_drain: actual %0d pending events, required 0",
               qB.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of independent player counters (1..8).
REQ-002 Parameter COUNT_W, default 8, width of the user and magic counts.
REQ-003 Parameter LEVEL_W, default 4, width of the level number.
REQ-004 Parameter MAX_LEVEL, default 9, final level; clearing it wins.
REQ-005 Parameter PRELIM_SECS, default 3; GAME_SECS, default 10; ANSWER_SECS, default 5; POST_SECS, default 3; all phase durations in seconds, each >=1.
REQ-006 Parameter TOLERANCE, default 0, largest allowed |userCount - magicCount| to survive a level.
REQ-007 Clk100M  in  1  single clock; every register updates on its rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 tick1Hz  in  1  one-cycle pulse once per second, synchronous to Clk100M.
REQ-010 start  in  1  one-cycle pulse that starts or restarts a game.
REQ-011 userUp, userDown  in  NUM_PLAYERS each  one-cycle blips, bit i belongs to player i.
REQ-012 magicCount  in  COUNT_W  number of special symbols from the symbol generator.
REQ-013 phase  out  3  0=IDLE 1=PRELIM 2=GAME 3=ANSWER 4=POST 5=OVER.
REQ-014 curLevel  out  LEVEL_W  current level, 1-based.
REQ-015 secsLeft  out  8  seconds remaining in the current phase.
REQ-016 genStart, genStop  out  1 each  one-cycle pulses to the symbol generator.
REQ-017 userCount  out  NUM_PLAYERS*COUNT_W  player i in bits [i*COUNT_W +: COUNT_W].
REQ-018 alive  out  NUM_PLAYERS  1 = player still in the game.
REQ-019 levelDone  out  1  one-cycle pulse when a level is passed; win, lose  out  1 each  sticky result flags.

Function
REQ-020 In IDLE, start moves the block to PRELIM on the next edge with secsLeft=PRELIM_SECS; start is ignored in PRELIM, GAME, ANSWER and POST.
REQ-021 In a timed phase, each tick1Hz decrements secsLeft; a tick seen while secsLeft==1 advances the state on that edge and loads the next phase duration into secsLeft. It never shows 0 in a timed phase.
REQ-022 Phase order is PRELIM -> GAME -> ANSWER -> POST; the exit from POST follows REQ-028.
REQ-023 genStart is 1 exactly in the first cycle of GAME; genStop is 1 exactly in the first cycle of ANSWER.
REQ-024 All userCount fields clear to 0 on the edge that enters GAME.
REQ-025 In GAME and ANSWER, for each alive player: up alone adds 1, saturating at 2^COUNT_W-1; down alone subtracts 1, saturating at 0; up and down together leave the count unchanged. Blips in other phases, or from dead players, are ignored.
REQ-026 magicCount is latched into an internal register during the genStop cycle; later changes to the input have no effect on that level.
REQ-027 On the edge that enters POST, alive[i] is cleared when |userCount[i] - latched magic| > TOLERANCE. The difference is computed unsigned in COUNT_W+1 bits. Alive bits are never set again before a new start.
REQ-028 At POST expiry:
- alive==0 -> OVER with lose=1.
- Otherwise, curLevel==MAX_LEVEL -> OVER with win=1.
- Otherwise, curLevel increments, levelDone pulses for one cycle, and the block goes to PRELIM.
REQ-029 In OVER, secsLeft=0, and win, lose, userCount and alive hold their values. start goes to PRELIM with curLevel=1, alive all ones, win=lose=0 and all counts 0.
REQ-030 A tick1Hz in the same cycle as a state-changing start does not decrement the newly loaded secsLeft.
REQ-031 Every output is driven from a register; there is no combinational path from any input to any output.

Reset
REQ-032 reset=0 at any edge forces, regardless of phase: phase=IDLE, curLevel=1, secsLeft=0, all userCount fields 0, alive all ones, genStart=genStop=levelDone=win=lose=0, latched magic 0.
REQ-033 Reset in the middle of a phase does not emit a genStop or levelDone pulse. Reset takes priority over start, tick1Hz and user blips in the same cycle.

Verification
REQ-034 Use defaults. start, then 3 ticks -> phase=2 and genStart pulses once; 10 more ticks -> phase=3 and genStop pulses once.
REQ-035 magicCount=5. Player0 gives 5 up blips and player1 gives 4 during GAME; after ANSWER expiry -> alive=2'b01, then curLevel=2 and levelDone pulses once at POST expiry.
REQ-036 Player0 gives 3 down blips from 0 -> count stays 0; 260 up blips -> count stays 255; up and down in the same cycle -> count unchanged.
REQ-037 Both players miss -> OVER, lose=1; start -> PRELIM, curLevel=1, alive=2'b11, lose=0.
REQ-038 MAX_LEVEL=1 and player0 correct -> OVER with win=1 and no levelDone pulse.
REQ-039 reset=0 in the 2nd GAME second with counts nonzero -> next edge phase=0, counts 0, no genStop pulse.
